// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory access stage: load/store bus FSM and MEM/WB register.
// Optional `MEM_MISALIGN_CHECK_EN turns unaligned loads/stores into exception code 4.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    output logic        bus_as,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy,
    output logic        busy,
    output logic [31:0] fwd_data,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_STORE    = 2'b10;
    localparam logic [2:0] EXP_MISALGN = 3'h4;

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t      state_q;
    logic        req_rw_q;
    logic [29:0] req_addr_q;
    logic [31:0] req_wr_data_q;
    logic [31:0] rd_data_q;
    logic        discard_q;

    logic [29:0] mem_pc_q;
    logic        mem_en_q;
    logic [4:0]  mem_dst_addr_q;
    logic        mem_gpr_we_q;
    logic [2:0]  mem_exp_code_q;
    logic [31:0] mem_out_q;

    logic is_mem_op;
    logic misalign;
    logic access_req;
    logic start;
    logic in_access;
    logic done;
    logic load_sel;
    logic discard_done;

    assign is_mem_op = ex_en && (ex_mem_op == OP_LOAD || ex_mem_op == OP_STORE)
                       && (ex_exp_code == 3'd0);
`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = is_mem_op && (ex_out[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign access_req   = is_mem_op && !misalign;
    assign start        = (state_q == IDLE) && access_req;
    assign in_access    = (state_q == ACCESS);
    assign done         = (start || in_access) && bus_rdy;
    assign load_sel     = start ? (ex_mem_op == OP_LOAD) : req_rw_q;
    assign discard_done = in_access && bus_rdy && discard_q;

    // Once in ACCESS the request comes from the latched copy so the bus stays stable.
    assign bus_as      = start || in_access;
    assign bus_rw      = in_access ? req_rw_q      : (ex_mem_op == OP_LOAD);
    assign bus_addr    = in_access ? req_addr_q    : ex_out[31:2];
    assign bus_wr_data = in_access ? req_wr_data_q : ex_mem_wr_data;
    assign busy        = (start || in_access) && !bus_rdy;

    always_comb begin
        fwd_data = ex_out;
        if (done && load_sel) begin
            fwd_data = bus_rd_data;
        end else if (state_q == HOLD && req_rw_q) begin
            fwd_data = rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_rw_q      <= 1'b0;
            req_addr_q    <= 30'd0;
            req_wr_data_q <= 32'd0;
            rd_data_q     <= 32'd0;
            discard_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_req) begin
                        req_rw_q      <= (ex_mem_op == OP_LOAD);
                        req_addr_q    <= ex_out[31:2];
                        req_wr_data_q <= ex_mem_wr_data;
                        if (bus_rdy) begin
                            rd_data_q <= bus_rd_data;
                            discard_q <= 1'b0;
                            state_q   <= (stall && !flush) ? HOLD : IDLE;
                        end else begin
                            discard_q <= flush;
                            state_q   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // A flush never aborts the bus cycle; it only marks the result as dead.
                    if (flush) begin
                        discard_q <= 1'b1;
                    end
                    if (bus_rdy) begin
                        rd_data_q <= bus_rd_data;
                        discard_q <= 1'b0;
                        state_q   <= (stall && !flush && !discard_q) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (flush || !stall) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_pc_q       <= 30'd0;
            mem_en_q       <= 1'b0;
            mem_dst_addr_q <= 5'd0;
            mem_gpr_we_q   <= 1'b1;
            mem_exp_code_q <= 3'd0;
            mem_out_q      <= 32'd0;
        end else if (flush || discard_done) begin
            mem_pc_q       <= 30'd0;
            mem_en_q       <= 1'b0;
            mem_dst_addr_q <= 5'd0;
            mem_gpr_we_q   <= 1'b1;
            mem_exp_code_q <= 3'd0;
            mem_out_q      <= 32'd0;
        end else if (!(stall || busy)) begin
            mem_pc_q       <= ex_pc;
            mem_en_q       <= ex_en;
            mem_dst_addr_q <= ex_dst_addr;
            mem_gpr_we_q   <= misalign ? 1'b1 : ex_gpr_we_;
            mem_exp_code_q <= misalign ? EXP_MISALGN : ex_exp_code;
            mem_out_q      <= fwd_data;
        end
    end

    assign mem_pc       = mem_pc_q;
    assign mem_en       = mem_en_q;
    assign mem_dst_addr = mem_dst_addr_q;
    assign mem_gpr_we_  = mem_gpr_we_q;
    assign mem_exp_code = mem_exp_code_q;
    assign mem_out      = mem_out_q;
endmodule
